mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_pkg.sv | 35 +++
 rtl/mem_stage_if.sv | 47 ++++
 rtl/load_store_align.sv | 100 ++++++++++
 rtl/mem_stage.sv | 139 +++++++++++++
 tb/tb_mem_stage.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mem_pkg
//  Purpose : Shared definitions for the memory (M) pipeline stage: the
//            access FSM state type and the Funct3 load/store encodings.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package mem_pkg;

    // Access FSM states, explicitly encoded.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    // Load encodings of Funct3.
    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;

    // Store encodings of Funct3 (share codes with the signed loads).
    localparam logic [2:0] c_F3_SB  = 3'b000;
    localparam logic [2:0] c_F3_SH  = 3'b001;
    localparam logic [2:0] c_F3_SW  = 3'b010;

    // Data bus geometry.
    localparam int c_XLEN  = 32;
    localparam int c_NBYTE = 4;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
//  Module  : mem_stage_if
//  Purpose : Data-memory request/acknowledge bus between the M stage and
//            the data memory.
//  Signals : dmem_req   - request valid, held until dmem_ack
//            dmem_we    - write enable (store)
//            dmem_addr  - word-aligned byte address
//            dmem_wdata - store data, already replicated into byte lanes
//            dmem_be    - byte-lane enables
//            dmem_rdata - read word returned with dmem_ack
//            dmem_ack   - transaction complete
//  Modports: master (M stage), slave (memory)
//  Rev     : 1.0  initial release
// ============================================================================
interface mem_stage_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        output dmem_be,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_be,
        output dmem_rdata,
        output dmem_ack
    );

endinterface : mem_stage_if
`default_nettype wire

// File: rtl/load_store_align.sv
`default_nettype none
// ============================================================================
//  Module  : load_store_align
//  Purpose : Purely combinational byte-lane steering for the M stage.
//            Stores: byte enables and lane-replicated write data.
//            Loads : byte/half/word selection and sign/zero extension.
//            Also flags misaligned or unsupported accesses.
//  Ports   : funct3      in  3   access size/sign
//            addr_lo     in  2   low address bits
//            is_load     in  1   load request
//            is_store    in  1   store request
//            store_data  in  32  raw store data
//            load_word   in  32  word returned by memory
//            byte_en     out 4   byte-lane enables
//            store_lanes out 32  replicated store data
//            load_data   out 32  extended load result
//            access_err  out 1   misaligned / illegal / load+store
//  Rev     : 1.0  initial release
// ============================================================================
module load_store_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_lanes,
    output logic [31:0] load_data,
    output logic        access_err
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection for sub-word loads.
    always_comb begin
        w_byte = load_word[7:0];
        case (addr_lo)
            2'd0:    w_byte = load_word[7:0];
            2'd1:    w_byte = load_word[15:8];
            2'd2:    w_byte = load_word[23:16];
            default: w_byte = load_word[31:24];
        endcase
        w_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];
    end

    always_comb begin
        byte_en     = 4'b0000;
        store_lanes = 32'h0;
        load_data   = 32'h0;
        access_err  = 1'b0;

        // Signed-load codes double as the store codes (SB/SH/SW).
        case (funct3)
            c_F3_LB: begin
                byte_en     = 4'b0001 << addr_lo;
                store_lanes = {4{store_data[7:0]}};
                load_data   = {{24{w_byte[7]}}, w_byte};
            end
            c_F3_LH: begin
                byte_en     = 4'b0011 << {addr_lo[1], 1'b0};
                store_lanes = {2{store_data[15:0]}};
                load_data   = {{16{w_half[15]}}, w_half};
                access_err  = addr_lo[0];
            end
            c_F3_LW: begin
                byte_en     = 4'b1111;
                store_lanes = store_data;
                load_data   = load_word;
                access_err  = |addr_lo;
            end
            c_F3_LBU: begin
                byte_en     = 4'b0001 << addr_lo;
                load_data   = {24'h0, w_byte};
                // Unsigned variants exist only for loads.
                access_err  = is_store;
            end
            c_F3_LHU: begin
                byte_en     = 4'b0011 << {addr_lo[1], 1'b0};
                load_data   = {16'h0, w_half};
                access_err  = is_store | addr_lo[0];
            end
            default: begin
                access_err  = 1'b1;
            end
        endcase

        if (is_load && is_store) begin
            access_err = 1'b1;
        end
        if (!is_load && !is_store) begin
            access_err = 1'b0;
        end
    end

endmodule : load_store_align
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module  : mem_stage
//  Purpose : Memory stage of the pipeline. Issues load/store transactions on
//            a req/ack data bus, stalls the pipeline while a transaction is
//            outstanding, extends returned load data and qualifies the
//            register-write enable.
//  Ports   : clk, rst              clock, asynchronous active-high reset
//            ValidM                M stage holds a real instruction
//            MemWriteM, MemReadM   store / load request
//            Funct3M               access size/sign
//            ALUResultM            byte address
//            WriteDataM            store data
//            RegWriteM             register write request
//            ReadDataM             extended load data (valid in DONE)
//            RegWriteQualM         qualified register write enable
//            StallM                freeze upstream pipeline registers
//            MemErrM               misaligned or illegal access
//            dmem                  data-memory bus (master side)
//  Rev     : 1.0  initial release
// ============================================================================
module mem_stage
    import mem_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                ValidM,
    input  logic                MemWriteM,
    input  logic                MemReadM,
    input  logic [2:0]          Funct3M,
    input  logic [31:0]         ALUResultM,
    input  logic [31:0]         WriteDataM,
    input  logic                RegWriteM,
    output logic [31:0]         ReadDataM,
    output logic                RegWriteQualM,
    output logic                StallM,
    output logic                MemErrM,
    mem_stage_if.master         dmem
);

    mem_state_t  state_q, state_d;
    logic [31:0] rdata_q, rdata_d;

    logic        w_mem_op;
    logic        w_access;
    logic        w_align_err;
    logic        w_req;
    logic        w_stall;
    logic [3:0]  w_be;
    logic [31:0] w_lanes;
    logic [31:0] w_load_data;

    // ------------------------------------------------------------------
    // Byte-lane steering; the load path works on the captured word so the
    // result is stable during DONE.
    // ------------------------------------------------------------------
    load_store_align u_align (
        .funct3      (Funct3M),
        .addr_lo     (ALUResultM[1:0]),
        .is_load     (MemReadM),
        .is_store    (MemWriteM),
        .store_data  (WriteDataM),
        .load_word   (rdata_q),
        .byte_en     (w_be),
        .store_lanes (w_lanes),
        .load_data   (w_load_data),
        .access_err  (w_align_err)
    );

    assign w_mem_op = ValidM & (MemReadM | MemWriteM);
    assign MemErrM  = w_mem_op & w_align_err;
    assign w_access = w_mem_op & ~MemErrM;

    // ------------------------------------------------------------------
    // State and capture registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        rdata_d   = rdata_q;
        w_req     = 1'b0;
        w_stall   = 1'b0;
        ReadDataM = 32'h0;

        case (state_q)
            ST_IDLE: begin
                // Stall already in the cycle the access is recognised so
                // the instruction stays put while the bus is busy.
                w_stall = w_access;
                if (w_access) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                w_req   = 1'b1;
                w_stall = 1'b1;
                if (dmem.dmem_ack) begin
                    state_d = ST_DONE;
                    rdata_d = dmem.dmem_rdata;
                end
            end
            ST_DONE: begin
                // Pipeline advances this cycle with the loaded value.
                ReadDataM = w_load_data;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset must silence the stall and write enable immediately, even while
    // the M-stage inputs still describe a memory access.
    assign StallM        = w_stall & ~rst;
    assign RegWriteQualM = RegWriteM & ValidM & ~StallM & ~MemErrM & ~rst;

    // Address/data come straight from the M-stage inputs, which are frozen
    // by StallM for as long as the request is outstanding.
    assign dmem.dmem_req   = w_req;
    assign dmem.dmem_we    = w_req & MemWriteM;
    assign dmem.dmem_addr  = {ALUResultM[31:2], 2'b00};
    assign dmem.dmem_wdata = w_lanes;
    assign dmem.dmem_be    = w_be;

endmodule : mem_stage
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mem_stage
//  Purpose : Self-checking bench for mem_stage: directed vector table,
//            reset sequences and randomized transactions against a
//            behavioural model of the access rules.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ValidM, MemWriteM, MemReadM, RegWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic [31:0] ReadDataM;
    logic        RegWriteQualM, StallM, MemErrM;

    mem_stage_if bus ();

    mem_stage dut (
        .clk           (clk),
        .rst           (rst),
        .ValidM        (ValidM),
        .MemWriteM     (MemWriteM),
        .MemReadM      (MemReadM),
        .Funct3M       (Funct3M),
        .ALUResultM    (ALUResultM),
        .WriteDataM    (WriteDataM),
        .RegWriteM     (RegWriteM),
        .ReadDataM     (ReadDataM),
        .RegWriteQualM (RegWriteQualM),
        .StallM        (StallM),
        .MemErrM       (MemErrM),
        .dmem          (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model of the access rules
    // ------------------------------------------------------------------
    function automatic int nbytes_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic model_err(input logic v, input logic rd, input logic wr,
                                       input logic [2:0] f3, input logic [31:0] addr);
        int n;
        if (!(v && (rd || wr))) return 1'b0;
        if (rd && wr) return 1'b1;
        if (rd && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
        if (wr && f3 > 3'd2) return 1'b1;
        n = nbytes_of(f3);
        return (addr % n) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] word);
        longint n, val, span;
        n    = nbytes_of(f3);
        span = longint'(1) << (8 * n);
        val  = (longint'(word) >> (8 * (addr % 4))) % span;
        if (!f3[2] && n < 4 && val >= span / 2) val = val - span;
        return val[31:0];
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        int n;
        n = nbytes_of(f3);
        return 4'(((1 << n) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (nbytes_of(f3))
            1:       return 32'(wd % 256) * 32'h0101_0101;
            2:       return 32'(wd % 65536) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // One instruction through the M stage. Called at posedge+1; returns at
    // posedge+1 of the cycle after the instruction leaves the stage.
    // ------------------------------------------------------------------
    task automatic run_txn(input string tag, input logic v, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                           input logic regw, input logic [31:0] rdw, input int delay,
                           input logic e_err, input logic [31:0] e_rdm, input logic [3:0] e_be,
                           input logic [31:0] e_wd);
        logic access;
        int   stalls;
        stalls     = 0;
        ValidM     = v;  MemReadM = rd; MemWriteM = wr; Funct3M = f3;
        ALUResultM = addr; WriteDataM = wd; RegWriteM = regw;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = $urandom;
        #3;
        access = v && (rd || wr) && !e_err;
        chk({tag, ".err"},   32'(MemErrM), 32'(e_err));
        chk({tag, ".req0"},  32'(bus.dmem_req), 32'd0);
        chk({tag, ".stl0"},  32'(StallM), 32'(access));
        chk({tag, ".rwq0"},  32'(RegWriteQualM), 32'(regw && v && !access && !e_err));
        chk({tag, ".rdm0"},  ReadDataM, 32'h0);
        if (StallM) stalls++;
        if (!access) begin
            @(posedge clk); #1;
            return;
        end
        for (int k = 0; k <= delay; k++) begin
            @(posedge clk); #1;
            bus.dmem_ack   = (k == delay);
            bus.dmem_rdata = (k == delay) ? rdw : $urandom;
            #3;
            chk({tag, ".req"},  32'(bus.dmem_req), 32'd1);
            chk({tag, ".addr"}, bus.dmem_addr, addr & 32'hFFFF_FFFC);
            chk({tag, ".we"},   32'(bus.dmem_we), 32'(wr));
            if (wr) begin
                chk({tag, ".be"},    32'(bus.dmem_be), 32'(e_be));
                chk({tag, ".wdata"}, bus.dmem_wdata, e_wd);
            end
            chk({tag, ".rwqR"}, 32'(RegWriteQualM), 32'd0);
            chk({tag, ".rdmR"}, ReadDataM, 32'h0);
            if (StallM) stalls++;
        end
        @(posedge clk); #1;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = $urandom;
        #3;
        chk({tag, ".stlD"}, 32'(StallM), 32'd0);
        chk({tag, ".reqD"}, 32'(bus.dmem_req), 32'd0);
        chk({tag, ".rwqD"}, 32'(RegWriteQualM), 32'(regw));
        if (rd) chk({tag, ".rdmD"}, ReadDataM, e_rdm);
        chk({tag, ".nstall"}, 32'(stalls), 32'(delay + 2));
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        v, rd, wr;
        logic [2:0]  f3;
        logic [31:0] addr, wd;
        logic        regw;
        logic [31:0] rdw;
        int          delay;
        logic        err;
        logic [31:0] rdm;
        logic [3:0]  be;
        logic [31:0] wdo;
    } vec_t;

    vec_t tbl [16];

    initial begin
        //          v  rd wr f3    addr          wd            rw rdw           dly err rdm           be     wdo
        tbl[0]  = '{1, 1, 0, 3'd2, 32'h0000_0100, 32'h0,        1, 32'hDEADBEEF, 2, 0, 32'hDEADBEEF, 4'hF, 32'h0};
        tbl[1]  = '{1, 1, 0, 3'd0, 32'h0000_0103, 32'h0,        1, 32'h80FF_FF7F, 0, 0, 32'hFFFF_FF80, 4'h8, 32'h0};
        tbl[2]  = '{1, 1, 0, 3'd4, 32'h0000_0103, 32'h0,        1, 32'h80FF_FF7F, 1, 0, 32'h0000_0080, 4'h8, 32'h0};
        tbl[3]  = '{1, 1, 0, 3'd1, 32'h0000_0102, 32'h0,        1, 32'h80FF_FF7F, 0, 0, 32'hFFFF_80FF, 4'hC, 32'h0};
        tbl[4]  = '{1, 1, 0, 3'd5, 32'h0000_0100, 32'h0,        1, 32'h80FF_FF7F, 3, 0, 32'h0000_FF7F, 4'h3, 32'h0};
        tbl[5]  = '{1, 0, 1, 3'd1, 32'h0000_0102, 32'h0000_ABCD, 0, 32'h0,       1, 0, 32'h0,         4'hC, 32'hABCD_ABCD};
        tbl[6]  = '{1, 0, 1, 3'd0, 32'h0000_0101, 32'h1234_5678, 0, 32'h0,       0, 0, 32'h0,         4'h2, 32'h7878_7878};
        tbl[7]  = '{1, 0, 1, 3'd2, 32'h0000_0104, 32'hCAFE_F00D, 0, 32'h0,       2, 0, 32'h0,         4'hF, 32'hCAFE_F00D};
        tbl[8]  = '{1, 1, 0, 3'd2, 32'h0000_0101, 32'h0,        1, 32'h0,        0, 1, 32'h0,         4'h0, 32'h0};
        tbl[9]  = '{1, 1, 0, 3'd1, 32'h0000_0101, 32'h0,        1, 32'h0,        0, 1, 32'h0,         4'h0, 32'h0};
        tbl[10] = '{1, 1, 0, 3'd3, 32'h0000_0100, 32'h0,        1, 32'h0,        0, 1, 32'h0,         4'h0, 32'h0};
        tbl[11] = '{1, 0, 1, 3'd4, 32'h0000_0100, 32'h0,        0, 32'h0,        0, 1, 32'h0,         4'h0, 32'h0};
        tbl[12] = '{1, 1, 1, 3'd2, 32'h0000_0100, 32'h0,        1, 32'h0,        0, 1, 32'h0,         4'h0, 32'h0};
        tbl[13] = '{1, 0, 0, 3'd0, 32'h0000_0055, 32'h0,        1, 32'h0,        0, 0, 32'h0,         4'h0, 32'h0};
        tbl[14] = '{0, 1, 0, 3'd2, 32'h0000_0101, 32'h0,        1, 32'h0,        0, 0, 32'h0,         4'h0, 32'h0};
        tbl[15] = '{1, 1, 0, 3'd0, 32'h0000_0100, 32'h0,        1, 32'h0000_007F, 0, 0, 32'h0000_007F, 4'h1, 32'h0};

        // ---------------- reset state, with a load presented ----------
        rst = 1'b1;
        ValidM = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'd2;
        ALUResultM = 32'h100; WriteDataM = 32'h0; RegWriteM = 1'b1;
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h5555_5555;
        #2;
        chk("rst.req",  32'(bus.dmem_req), 32'd0);
        chk("rst.stall", 32'(StallM), 32'd0);
        chk("rst.rdm",  ReadDataM, 32'h0);
        chk("rst.rwq",  32'(RegWriteQualM), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; ValidM = 1'b0; bus.dmem_ack = 1'b0;
        #3;
        chk("rel.stall", 32'(StallM), 32'd0);
        @(posedge clk); #1;

        // ---------------- directed table -----------------------------
        for (int i = 0; i < 16; i++) begin
            run_txn($sformatf("v%0d", i), tbl[i].v, tbl[i].rd, tbl[i].wr, tbl[i].f3,
                    tbl[i].addr, tbl[i].wd, tbl[i].regw, tbl[i].rdw, tbl[i].delay,
                    tbl[i].err, tbl[i].rdm, tbl[i].be, tbl[i].wdo);
        end

        // ---------------- reset in the middle of a request -----------
        ValidM = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'd2;
        ALUResultM = 32'h200; RegWriteM = 1'b1; bus.dmem_ack = 1'b0;
        #3;
        chk("mr.stl_idle", 32'(StallM), 32'd1);
        @(posedge clk); #1;
        #2;
        chk("mr.req", 32'(bus.dmem_req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mr.req_rst",   32'(bus.dmem_req), 32'd0);
        chk("mr.stall_rst", 32'(StallM), 32'd0);
        chk("mr.rwq_rst",   32'(RegWriteQualM), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; ValidM = 1'b0;
        @(posedge clk); #1;
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h1111_1111;
        #3;
        chk("mr.late_req", 32'(bus.dmem_req), 32'd0);
        chk("mr.late_stl", 32'(StallM), 32'd0);
        @(posedge clk); #1;
        bus.dmem_ack = 1'b0;
        #3;
        chk("mr.nodone_rdm", ReadDataM, 32'h0);
        chk("mr.nodone_req", 32'(bus.dmem_req), 32'd0);
        chk("mr.nodone_stl", 32'(StallM), 32'd0);
        @(posedge clk); #1;
        run_txn("mr.recover", 1, 1, 0, 3'd2, 32'h204, 32'h0, 1, 32'h2468_ACE0, 1,
                0, 32'h2468_ACE0, 4'hF, 32'h0);

        // ---------------- randomized transactions --------------------
        for (int n = 0; n < 120; n++) begin
            logic        v, rd, wr, rw, e;
            logic [2:0]  f3;
            logic [31:0] a, wd, rdw;
            int          kind, dly;
            v    = ($urandom % 8) != 0;
            kind = $urandom % 8;
            rd   = (kind < 3) || (kind == 7);
            wr   = (kind >= 3 && kind < 6) || (kind == 7);
            f3   = 3'($urandom % 8);
            a    = $urandom;
            wd   = $urandom;
            rdw  = $urandom;
            rw   = 1'($urandom % 2);
            dly  = $urandom % 4;
            e    = model_err(v, rd, wr, f3, a);
            run_txn($sformatf("r%0d", n), v, rd, wr, f3, a, wd, rw, rdw, dly,
                    e, model_load(f3, a, rdw), model_be(f3, a), model_wdata(f3, wd));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_stage
`default_nettype wire
